// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears the MAC, streams len operand pairs from the A/B banks,
// drains the MAC pipeline and offers the Q16.16 result on a valid/ready port.
module mac_dot_seq #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_a,
    input  logic [DATA_W-1:0] rd_b,
    output logic              mac_clr,
    output logic              mac_en,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_p,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] cnt;
    logic              en_q;
    logic              held;
    logic [ACC_W-1:0]  res_q;
    logic              last;

    assign last = ({1'b0, cnt} == (len_q - 1'b1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        mac_clr   = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = CLEAR;
            CLEAR: begin
                mac_clr   = 1'b1;
                state_nxt = (len_q == '0) ? DONE : RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign rd_addr = rd_en ? cnt : '0;
    assign mac_en  = en_q;
    assign mac_a   = rd_a;
    assign mac_b   = rd_b;

    // The final accumulate lands on the same edge that enters DONE, so the first DONE
    // cycle shows mac_p directly and the value is frozen in res_q from then on.
    assign res_data = res_valid ? (held ? res_q : mac_p) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            cnt   <= '0;
            en_q  <= 1'b0;
            held  <= 1'b0;
            res_q <= '0;
        end else begin
            en_q <= rd_en;
            if (state == IDLE && start)
                len_q <= (len > DEPTH_L) ? DEPTH_L : len;
            if (state == CLEAR)
                cnt <= '0;
            else if (state == RUN && !last)
                cnt <= cnt + 1'b1;
            if (state == DONE) begin
                if (!held) begin
                    res_q <= mac_p;
                    held  <= 1'b1;
                end
                if (res_ready) held <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Scoreboard bench for mac_dot_seq with a behavioural operand memory and Q8.8 MAC.
module tb_mac_dot_seq;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_a = '0;
    logic [DATA_W-1:0] rd_b = '0;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_a;
    logic [DATA_W-1:0] mac_b;
    logic [ACC_W-1:0]  mac_p = 32'hDEAD_BEEF;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [ACC_W-1:0]  res_data;

    mac_dot_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_p(mac_p), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem_a [16];
    logic [DATA_W-1:0] mem_b [16];
    logic signed [ACC_W-1:0] prod;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a <= mem_a[rd_addr];
            rd_b <= mem_b[rd_addr];
        end
    end

    // MAC is deliberately not reset: only mac_clr may remove a previous job's residue
    always @(posedge clk) begin
        prod = $signed(mac_a) * $signed(mac_b);
        if (mac_clr)     mac_p <= '0;
        else if (mac_en) mac_p <= mac_p + prod;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          reads;
        int          cycle;
    } exp_t;

    exp_t expq[$];
    int   start_cyc = -100;
    int   tmo_cnt = 0;
    bit   end_req = 1'b0;

    int          checks = 0;
    int          failures = 0;
    int          clr_cnt = 0;
    int          en_cnt = 0;
    int          rd_cnt = 0;
    bit          overlap = 1'b0;
    bit          prev_valid = 1'b0;
    bit          prev_busy = 1'b0;
    bit          prev_hs = 1'b0;
    bit          end_done = 1'b0;
    int          tmo_seen = 0;
    logic [31:0] held_data = '0;
    exp_t        e;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: all comparisons happen here, on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("reset_outputs",
                        {23'd0, busy, rd_en, rd_addr, mac_clr, mac_en, res_valid, res_data}, 64'd0);
            clr_cnt = 0; en_cnt = 0; rd_cnt = 0; overlap = 1'b0;
            prev_valid = 1'b0; prev_busy = 1'b0; prev_hs = 1'b0;
        end else begin
            if (prev_hs) checkOutput("idle_after_handshake", {62'd0, busy, res_valid}, 64'd0);
            if (busy && !prev_busy) checkOutput("busy_rise_cycle", 64'(cyc), 64'(start_cyc));
            if (mac_clr) begin
                clr_cnt++;
                rd_cnt = 0;
                en_cnt = 0;
            end
            if (mac_clr && mac_en) overlap = 1'b1;
            if (rd_en) begin
                checkOutput("rd_addr", 64'(rd_addr), 64'(rd_cnt));
                rd_cnt++;
            end
            if (mac_en) en_cnt++;
            if (res_valid && !prev_valid) begin
                if (expq.size() == 0) begin
                    failNow("unexpected_result");
                end else begin
                    e = expq.pop_front();
                    checkOutput("res_data", 64'(res_data), 64'(e.data));
                    checkOutput("valid_cycle", 64'(cyc - start_cyc + 1), 64'(e.cycle));
                    checkOutput("mac_en_count", 64'(en_cnt), 64'(e.reads));
                    checkOutput("rd_en_count", 64'(rd_cnt), 64'(e.reads));
                    checkOutput("mac_clr_count", 64'(clr_cnt), 64'd1);
                    checkOutput("clr_en_overlap", 64'(overlap), 64'd0);
                end
                held_data = res_data;
                clr_cnt = 0;
                overlap = 1'b0;
            end else if (res_valid) begin
                checkOutput("held_data", 64'(res_data), 64'(held_data));
            end
            if (res_valid) checkOutput("busy_in_done", 64'(busy), 64'd1);
            prev_hs    = res_valid && res_ready;
            prev_valid = res_valid;
            prev_busy  = busy;
        end
        if (tmo_cnt != tmo_seen) begin
            tmo_seen = tmo_cnt;
            failNow("wait_timeout");
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            checkOutput("queue_empty", 64'(expq.size()), 64'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; start is sampled at the next edge (E0)
    task automatic applyStimulus(input int n, input logic [31:0] d, input int reads,
                                 input int cycl, input bit expect_res);
        if (expect_res) expq.push_back('{d, reads, cycl});
        start = 1'b1;
        len   = (ADDR_W + 1)'(n);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic waitValid(input int bound);
        int k = 0;
        while (!res_valid && k < bound) begin
            tick(1);
            k++;
        end
        if (!res_valid) tmo_cnt++;
    endtask

    task automatic waitIdle(input int bound);
        int k = 0;
        while (busy && k < bound) begin
            tick(1);
            k++;
        end
        if (busy) tmo_cnt++;
    endtask

    task automatic loadVec4();
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        mem_a[0] = 16'd256;  mem_b[0] = 16'd256;
        mem_a[1] = 16'd512;  mem_b[1] = 16'd128;
        mem_a[2] = 16'hFF00; mem_b[2] = 16'd256;
        mem_a[3] = 16'd128;  mem_b[3] = 16'd512;
    endtask

    initial begin
        int k;
        loadVec4();
        tick(3);
        rst = 1'b1;
        tick(2);

        // len=1: 1.0 * 1.0
        applyStimulus(1, 32'h0001_0000, 1, 4, 1'b1);
        waitValid(50);
        waitIdle(10);
        tick(1);

        // len=4: 1.0 + 1.0 - 1.0 + 1.0 = 2.0
        applyStimulus(4, 32'h0002_0000, 4, 7, 1'b1);
        waitValid(50);
        waitIdle(10);
        tick(1);

        // back-pressure, start during DONE, then ready and start in the same cycle
        res_ready = 1'b0;
        applyStimulus(4, 32'h0002_0000, 4, 7, 1'b1);
        waitValid(50);
        tick(2);
        start = 1'b1;
        len   = 5'd2;
        tick(1);
        start = 1'b0;
        len   = '0;
        tick(2);
        res_ready = 1'b1;
        start = 1'b1;
        len   = 5'd1;
        tick(1);
        start = 1'b0;
        len   = '0;
        tick(3);

        // len=0: clear only
        applyStimulus(0, 32'h0000_0000, 0, 2, 1'b1);
        waitValid(50);
        waitIdle(10);
        tick(1);

        // len=20 clamps to 16 reads of 1.0*1.0
        for (int i = 0; i < 16; i++) begin
            mem_a[i] = 16'd256;
            mem_b[i] = 16'd256;
        end
        applyStimulus(20, 32'h0010_0000, 16, 19, 1'b1);
        waitValid(60);
        waitIdle(10);
        tick(1);

        // abort during RUN at cnt=2, then a clean len=1 job
        loadVec4();
        applyStimulus(4, 32'h0, 0, 0, 1'b0);
        k = 0;
        while (!(rd_en && rd_addr == 4'd1) && k < 20) begin
            tick(1);
            k++;
        end
        if (!(rd_en && rd_addr == 4'd1)) tmo_cnt++;
        tick(1);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        applyStimulus(1, 32'h0001_0000, 1, 4, 1'b1);
        waitValid(50);
        waitIdle(10);
        tick(1);

        // back-to-back: second start in the first IDLE cycle after the handshake
        applyStimulus(4, 32'h0002_0000, 4, 7, 1'b1);
        waitValid(50);
        tick(1);
        applyStimulus(1, 32'h0001_0000, 1, 4, 1'b1);
        waitValid(50);
        waitIdle(10);
        tick(2);

        end_req = 1'b1;
        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
